// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns engine: accepts a 128-bit state, transforms one column
// per clock through a shared GF(2^8) datapath, and presents the result over valid/ready.
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] data_q, data_d;
    logic [127:0] result_q, result_d;
    logic [31:0]  colIn;
    logic [31:0]  colOut;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        mixColumn[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        mixColumn[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        mixColumn[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        mixColumn[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    endfunction

    // Column 0 occupies the most significant word of the state.
    always_comb begin
        colIn = data_q[127:96];
        case (col_q)
            2'd0:    colIn = data_q[127:96];
            2'd1:    colIn = data_q[95:64];
            2'd2:    colIn = data_q[63:32];
            default: colIn = data_q[31:0];
        endcase
        colOut = mixColumn(colIn);
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        data_d   = data_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    col_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                case (col_q)
                    2'd0:    result_d[127:96] = colOut;
                    2'd1:    result_d[95:64]  = colOut;
                    2'd2:    result_d[63:32]  = colOut;
                    default: result_d[31:0]   = colOut;
                endcase
                if (col_q == 2'd3) begin
                    col_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            col_q    <= 2'd0;
            data_q   <= 128'h0;
            result_q <= 128'h0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            data_q   <= data_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = result_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: table-driven vectors plus hand-written
// sequences for backpressure, mid-block input changes, reset abort and back-to-back blocks.
module tb_mix_columns_seq;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
        string        name;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    int compared;
    int mismatched;
    int edgeCount;
    int acceptCount;
    int acceptEdges[$];
    vec_t vecs[5];

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records the edge number of every accepted input state.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) begin
            acceptEdges.push_back(edgeCount);
            acceptCount <= acceptCount + 1;
        end
        edgeCount <= edgeCount + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Counts cycles until out_valid, starting from the supplied count; bounded.
    task automatic waitValid(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finishHandshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, " out_valid after handshake"}, 128'(out_valid), 128'(0));
        checkOutput({name, " in_ready after handshake"}, 128'(in_ready), 128'(1));
    endtask

    task automatic applyStimulus(input logic [127:0] din, input logic [127:0] exp, input string name);
        int lat;
        checkOutput({name, " in_ready before accept"}, 128'(in_ready), 128'(1));
        in_valid  = 1'b1;
        data_in   = din;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        waitValid(0, lat);
        checkOutput({name, " latency"}, 128'(lat), 128'(4));
        checkOutput({name, " data_out"}, data_out, exp);
        finishHandshake(name);
    endtask

    initial begin
        int lat;
        int accBefore;
        int cnt;
        compared    = 0;
        mismatched  = 0;
        edgeCount   = 0;
        acceptCount = 0;

        vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6,
                    128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, "fips"};
        vecs[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                    128'h046681e5_e0cb199a_48f8d37a_2806264c, "round1"};
        vecs[2] = '{128'hd4d4d4d5_2d26314c_00000000_c6c6c6c6,
                    128'hd5d5d7d6_4d7ebdf8_00000000_c6c6c6c6, "mixed"};
        vecs[3] = '{128'h80000000_00800000_00008000_00000080,
                    128'h1b80809b_9b1b8080_809b1b80_80809b1b, "reduce"};
        vecs[4] = '{128'h0, 128'h0, "zero"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = 128'h0;
        #2;
        checkOutput("reset in_ready", 128'(in_ready), 128'(1));
        checkOutput("reset out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset data_out", data_out, 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset in_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].din, vecs[i].dout, vecs[i].name);
        end

        // Backpressure: result must hold while the consumer stalls.
        in_valid = 1'b1;
        data_in  = vecs[1].din;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitValid(0, lat);
        checkOutput("bp latency", 128'(lat), 128'(4));
        checkOutput("bp data_out", data_out, vecs[1].dout);
        accBefore = acceptCount;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            checkOutput("bp out_valid hold", 128'(out_valid), 128'(1));
            checkOutput("bp data_out hold", data_out, vecs[1].dout);
            checkOutput("bp in_ready hold", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        checkOutput("bp no accept", 128'(acceptCount - accBefore), 128'(0));
        finishHandshake("bp");
        checkOutput("bp data_out after handshake", data_out, vecs[1].dout);

        // Input changes while BUSY must not disturb the captured state.
        in_valid = 1'b1;
        data_in  = vecs[0].din;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        data_in  = {128{1'b1}};
        waitValid(1, lat);
        in_valid = 1'b0;
        checkOutput("busy-change latency", 128'(lat), 128'(4));
        checkOutput("busy-change data_out", data_out, vecs[0].dout);
        finishHandshake("busy-change");

        // Reset between E2 and E3 aborts the block at once.
        in_valid = 1'b1;
        data_in  = vecs[2].din;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort out_valid", 128'(out_valid), 128'(0));
        checkOutput("abort data_out", data_out, 128'h0);
        checkOutput("abort in_ready", 128'(in_ready), 128'(1));
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(vecs[1].din, vecs[1].dout, "after-abort");

        // Back-to-back blocks with in_valid held high.
        acceptEdges.delete();
        in_valid  = 1'b1;
        data_in   = vecs[0].din;
        out_ready = 1'b1;
        waitValid(0, cnt);
        checkOutput("b2b first data_out", data_out, vecs[0].dout);
        data_in = vecs[1].din;
        cnt = 0;
        while (acceptEdges.size() < 2 && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        in_valid = 1'b0;
        checkOutput("b2b spacing",
                    (acceptEdges.size() >= 2) ? 128'(acceptEdges[1] - acceptEdges[0]) : 128'(0),
                    128'(6));
        waitValid(0, lat);
        checkOutput("b2b second latency", 128'(lat), 128'(4));
        checkOutput("b2b second data_out", data_out, vecs[1].dout);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("b2b final out_valid", 128'(out_valid), 128'(0));
        checkOutput("b2b final in_ready", 128'(in_ready), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Iterative AES MixColumns engine for the encryption datapath. It is the forward-direction counterpart of the decryption-side InvMixColumns multiply-by-{09,0B,0D,0E} logic. It accepts one 128-bit AES state over a valid/ready handshake and transforms one column per clock using GF(2^8) multiply-by-{02,03}. It presents the result over a second valid/ready handshake. It sits between ShiftRows and AddRoundKey in the round pipeline.

## Interface
- Parameters: none.
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in holds a state to transform.
- in_ready  output  1  block can accept a state (high only in IDLE).
- data_in  input  128  input state; byte k = data_in[127-8k -: 8]; column c = bytes 4c..4c+3 (row 0 first).
- out_valid  output  1  data_out holds a completed result.
- out_ready  input  1  consumer accepts data_out.
- data_out  output  128  transformed state, same byte/column ordering as data_in.

## Operation
- Reset is asynchronous and active-high. While rst is high, and after its release:
  - state = IDLE, column counter = 0
  - captured state and result registers = 0
  - out_valid = 0, data_out = 128'h0, in_ready = 1
- States:
  - IDLE
    - in_ready = 1.
    - On in_valid at a clock edge: capture data_in, set col = 0, go to BUSY.
  - BUSY
    - in_ready = 0, out_valid = 0.
    - Each edge writes column col of the result from column col of the captured state, then increments col.
    - The edge that writes col = 3 goes to DONE.
  - DONE
    - out_valid = 1; data_out is stable.
    - On out_ready at an edge: go to IDLE, out_valid drops to 0. data_out keeps its value until the next block overwrites it.
    - If out_ready stays low, the block holds indefinitely. in_valid is ignored.
- Column math, for input bytes a0..a3 → output bytes b0..b3:
  - b0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - b1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - b2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - b3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- Multiply rules, all 8-bit with no width growth:
  - 2·x = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00)
  - 3·x = 2·x ^ x
- A single shared column datapath is muxed by col. The column counter is 2 bits and never wraps past 3 within a block.
- In BUSY, data_in and in_valid are don't-care; a changed data_in must not affect the in-flight block.
- Reset asserted mid-BUSY or mid-DONE aborts the block immediately: all outputs go to their reset values and no partial result is presented.

## Timing
- Accept edge E0 (IDLE, in_valid = 1). Column edges are E1..E4. out_valid rises after E4.
  - Latency is 4 cycles from the accept edge to out_valid.
- Output handshake completes at the first edge with out_valid & out_ready. IDLE (in_ready = 1) holds from the following cycle.
- Minimum spacing between accepts is 6 edges: accept, 4 columns, output handshake, then accept in IDLE.
- in_ready and out_valid are decoded from registered state only. No combinational path from in_valid/out_ready to any output.
- data_out may change during BUSY; consumers sample it only when out_valid = 1.

## Test plan
- FIPS-197 vector:
  - data_in = db135345_f20a225c_01010101_c6c6c6c6, out_ready = 1.
  - Required: out_valid 4 cycles after accept; data_out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
- Second vector:
  - data_in = d4bf5d30_e0b452ae_b84111f1_1e2798e5.
  - Required: data_out = 046681e5_e0cb199a_48f8d37a_2806264c.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid, toggling in_valid and data_in meanwhile.
  - Required: out_valid and data_out stable, in_ready = 0, no new accept. Release out_ready: one-cycle handshake, then in_ready = 1.
- Input change during BUSY:
  - Change data_in to all-FF on E2.
  - Required: result still equals the vector captured at E0.
- Reset mid-operation:
  - Assert rst asynchronously between E2 and E3.
  - Required: out_valid = 0, data_out = 0, in_ready = 1 immediately. After release, a new block completes correctly with 4-cycle latency.
- Back-to-back blocks:
  - in_valid held high with two states, out_ready = 1.
  - Required: both results correct, in order; second accept occurs exactly 6 edges after the first.
